// File: rtl/if_id_queue.sv
// if_id_queue: IF->ID decoupling FIFO carrying {pc, inst, tag} per entry.
// Valid/ready on both sides, single-cycle flush from EX, zero bubble to ID when empty.
module if_id_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int TAG_W  = 2,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         if_valid_i,
    input  logic [ADDR_W-1:0]            if_pc_i,
    input  logic [INST_W-1:0]            if_inst_i,
    input  logic [TAG_W-1:0]             if_tag_i,
    output logic                         if_ready_o,
    output logic                         id_valid_o,
    output logic [ADDR_W-1:0]            id_pc_o,
    output logic [INST_W-1:0]            id_inst_o,
    output logic [TAG_W-1:0]             id_tag_o,
    input  logic                         id_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = ADDR_W + INST_W + TAG_W;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] head;
    logic             push, pop;

    // Handshakes qualify against registered status only, so no input reaches an output combinationally.
    assign if_ready_o = (count_q != CNT_W'(DEPTH));
    assign id_valid_o = (count_q != '0);
    assign push       = if_valid_i & if_ready_o;
    assign pop        = id_ready_i & id_valid_o;
    assign count_o    = count_q;
    assign head       = mem_q[rd_ptr_q];

    // Next pointer/occupancy; flush wins over any push or pop in the same cycle.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state; async reset drops all entries immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush_i) mem_q[wr_ptr_q] <= {if_pc_i, if_inst_i, if_tag_i};
    end

    // Head presentation, forced to a zero bubble while empty.
    always_comb begin
        id_pc_o   = '0;
        id_inst_o = '0;
        id_tag_o  = '0;
        if (id_valid_o) begin
            id_pc_o   = head[ENT_W-1 -: ADDR_W];
            id_inst_o = head[TAG_W +: INST_W];
            id_tag_o  = head[TAG_W-1:0];
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue (DEPTH=4) using a scoreboard queue model.
module tb_if_id_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  tag;
    } ent_t;

    logic        clk, rst, flush, if_valid, id_ready;
    logic [31:0] pc_in, inst_in;
    logic [1:0]  tag_in;
    logic        if_ready, id_valid;
    logic [31:0] id_pc, id_inst;
    logic [1:0]  id_tag;
    logic [2:0]  count;

    ent_t sb[$];
    int   chk = 0;
    int   err = 0;

    if_id_queue #(.ADDR_W(32), .INST_W(32), .TAG_W(2), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .if_valid_i(if_valid), .if_pc_i(pc_in), .if_inst_i(inst_in), .if_tag_i(tag_in),
        .if_ready_o(if_ready), .id_valid_o(id_valid),
        .id_pc_o(id_pc), .id_inst_o(id_inst), .id_tag_o(id_tag),
        .id_ready_i(id_ready), .count_o(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, updating the scoreboard with what the queue should do.
    task automatic tick();
        bit   psh, pp;
        ent_t e;
        psh = if_valid && !flush && (sb.size() < DEPTH);
        pp  = id_ready && !flush && (sb.size() != 0);
        e.pc = pc_in; e.inst = inst_in; e.tag = tag_in;
        @(posedge clk);
        if (flush) sb.delete();
        else begin
            if (pp)  void'(sb.pop_front());
            if (psh) sb.push_back(e);
        end
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; if_valid = 0; id_ready = 0; pc_in = '0; inst_in = '0; tag_in = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        @(posedge clk); #1;
        sb.delete();
        rst = 1;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] inst, input logic [1:0] tag);
        if_valid = 1; pc_in = pc; inst_in = inst; tag_in = tag;
        tick();
        if_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        chk++; if (if_ready !== 1'b1) begin err++; $display("FAIL reset_ready got %0b want 1", if_ready); end
        chk++; if (id_valid !== 1'b0) begin err++; $display("FAIL reset_valid got %0b want 0", id_valid); end
        chk++; if (count !== 3'd0) begin err++; $display("FAIL reset_count got %0d want 0", count); end
        chk++; if ({id_pc, id_inst, id_tag} !== 66'd0) begin err++; $display("FAIL reset_data got pc=%h inst=%h tag=%0d want 0", id_pc, id_inst, id_tag); end
    endtask

    task automatic test_fill3();
        do_reset();
        for (int i = 0; i < 3; i++) push_one(32'(i * 4), 32'hA0 + 32'(i), 2'(i));
        chk++; if (count !== 3'(sb.size()) || count !== 3'd3) begin err++; $display("FAIL fill3_count got %0d want 3", count); end
        chk++; if (id_pc !== sb[0].pc || id_pc !== 32'h0) begin err++; $display("FAIL fill3_pc got %h want 0", id_pc); end
        chk++; if (id_inst !== sb[0].inst || id_inst !== 32'hA0) begin err++; $display("FAIL fill3_inst got %h want a0", id_inst); end
        chk++; if (id_valid !== 1'b1) begin err++; $display("FAIL fill3_valid got %0b want 1", id_valid); end
    endtask

    task automatic test_full();
        logic [31:0] exp_pc;
        do_reset();
        for (int i = 0; i < 4; i++) push_one(32'(i * 4), 32'hB0 + 32'(i), 2'(i));
        chk++; if (if_ready !== 1'b0) begin err++; $display("FAIL full_ready got %0b want 0", if_ready); end
        chk++; if (count !== 3'd4) begin err++; $display("FAIL full_count got %0d want 4", count); end
        push_one(32'h10, 32'hBF, 2'd3);
        chk++; if (count !== 3'd4 || sb.size() != 4) begin err++; $display("FAIL full_5th_ignored count got %0d want 4", count); end
        id_ready = 1; #1;
        chk++; if (if_ready !== 1'b0) begin err++; $display("FAIL full_no_comb_reopen got %0b want 0", if_ready); end
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'(i * 4);
            chk++;
            if (!id_valid || id_pc !== exp_pc || id_pc !== sb[0].pc || id_inst !== sb[0].inst || id_tag !== sb[0].tag) begin
                err++; $display("FAIL full_pop%0d got pc=%h inst=%h tag=%0d want pc=%h inst=%h tag=%0d", i, id_pc, id_inst, id_tag, exp_pc, sb[0].inst, sb[0].tag);
            end
            tick();
            if (i == 0) begin
                chk++; if (if_ready !== 1'b1 || count !== 3'd3) begin err++; $display("FAIL full_reopen ready=%0b count=%0d want 1/3", if_ready, count); end
            end
        end
        id_ready = 0;
        chk++; if (id_valid !== 1'b0 || count !== 3'd0 || id_pc !== 32'h0) begin err++; $display("FAIL full_drained valid=%0b count=%0d pc=%h want 0/0/0", id_valid, count, id_pc); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        do_reset();
        push_one(32'h200, 32'hC0, 2'd0);
        for (int i = 0; i < 10; i++) begin
            exp_pc = 32'h200 + 32'(i * 4);
            if_valid = 1; id_ready = 1;
            pc_in = 32'h204 + 32'(i * 4); inst_in = 32'hC1 + 32'(i); tag_in = 2'(i + 1);
            chk++;
            if (count !== 3'd1 || id_pc !== exp_pc || id_pc !== sb[0].pc || id_inst !== sb[0].inst || id_tag !== sb[0].tag) begin
                err++; $display("FAIL stream%0d got count=%0d pc=%h inst=%h want count=1 pc=%h inst=%h", i, count, id_pc, id_inst, exp_pc, sb[0].inst);
            end
            tick();
        end
        if_valid = 0; id_ready = 0;
        chk++; if (count !== 3'd1 || id_pc !== 32'h228) begin err++; $display("FAIL stream_end got count=%0d pc=%h want 1/228", count, id_pc); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) push_one(32'h20 + 32'(i * 4), 32'hD0 + 32'(i), 2'(i));
        flush = 1; if_valid = 1; pc_in = 32'h40; inst_in = 32'hDD; tag_in = 2'd1;
        tick();
        flush = 0; if_valid = 0;
        chk++; if (count !== 3'd0 || id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0 || if_ready !== 1'b1) begin
            err++; $display("FAIL flush count=%0d valid=%0b pc=%h inst=%h ready=%0b want 0/0/0/0/1", count, id_valid, id_pc, id_inst, if_ready);
        end
        tick();
        chk++; if (id_valid !== 1'b0 || sb.size() != 0) begin err++; $display("FAIL flush_drop got valid=%0b pc=%h want 0", id_valid, id_pc); end
        flush = 1; tick(); flush = 0;
        push_one(32'h44, 32'hD4, 2'd2);
        chk++; if (id_pc !== sb[0].pc || id_pc !== 32'h44 || count !== 3'd1) begin err++; $display("FAIL flush_after got pc=%h count=%0d want 44/1", id_pc, count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        push_one(32'h80, 32'hE0, 2'd1);
        push_one(32'h84, 32'hE1, 2'd2);
        #2 rst = 0;
        #1;
        sb.delete();
        chk++; if (count !== 3'd0 || id_valid !== 1'b0 || if_ready !== 1'b1 || id_pc !== 32'h0 || id_inst !== 32'h0) begin
            err++; $display("FAIL async_rst count=%0d valid=%0b ready=%0b pc=%h want 0/0/1/0", count, id_valid, if_ready, id_pc);
        end
        #2 rst = 1;
        push_one(32'h100, 32'hE5, 2'd3);
        chk++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_pc !== sb[0].pc || id_inst !== sb[0].inst) begin
            err++; $display("FAIL async_release got valid=%0b pc=%h want 1/100", id_valid, id_pc);
        end
    endtask

    task automatic test_empty_pop();
        do_reset();
        id_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk++; if (id_valid !== 1'b0 || count !== 3'd0 || {id_pc, id_inst, id_tag} !== 66'd0) begin
                err++; $display("FAIL empty_pop%0d valid=%0b count=%0d pc=%h inst=%h want 0", i, id_valid, count, id_pc, id_inst);
            end
        end
        id_ready = 0;
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        test_reset();
        test_fill3();
        test_full();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_empty_pop();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
